// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: display reads (fixed latency, top priority),
// optional clear engine (FB_CLEAR_EN), then the req/ack pixel writer.
module vga_fb_arbiter #(
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 3,
    parameter int WR_TIMEOUT = 64
`ifdef FB_CLEAR_EN
    ,
    parameter int                FB_DEPTH    = 1048576,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
`endif
) (
    input  logic              i_sysclk,
    input  logic              i_rst,
    input  logic              i_disp_req,
    input  logic [ADDR_W-1:0] i_disp_addr,
    output logic [DATA_W-1:0] o_disp_data,
    output logic              o_disp_valid,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ack,
    output logic              o_wr_starve,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
`ifdef FB_CLEAR_EN
    ,
    input  logic              i_clear_start,
    output logic              o_clear_busy
`endif
);

    localparam int CNT_W = $clog2(WR_TIMEOUT + 2);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_CLR} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_wr_ack;
    logic              r_starve;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic              r_rd_pend;
    logic              r_disp_valid;
    logic [DATA_W-1:0] r_disp_data;
    logic              w_clr_run;
    logic              w_wr_block;

`ifdef FB_CLEAR_EN
    logic              r_clr_busy;
    logic              r_clr_drain;
    logic [ADDR_W-1:0] r_clr_addr;

    // The drain cycle keeps busy high while the final clear write is on the bus.
    assign w_clr_run  = r_clr_busy & ~r_clr_drain;
    assign w_wr_block = r_clr_busy | i_clear_start;
    assign o_clear_busy = r_clr_busy;

    always_ff @(posedge i_sysclk) begin
        if (i_rst) begin
            r_clr_busy  <= 1'b0;
            r_clr_drain <= 1'b0;
            r_clr_addr  <= '0;
        end else begin
            if (!r_clr_busy && i_clear_start) begin
                r_clr_busy <= 1'b1;
            end else if (r_clr_drain) begin
                r_clr_busy  <= 1'b0;
                r_clr_drain <= 1'b0;
            end
            if (w_next == S_CLR) begin
                if (r_clr_addr == ADDR_W'(FB_DEPTH - 1)) begin
                    r_clr_addr  <= '0;
                    r_clr_drain <= 1'b1;
                end else begin
                    r_clr_addr <= r_clr_addr + ADDR_W'(1);
                end
            end
        end
    end
`else
    assign w_clr_run  = 1'b0;
    assign w_wr_block = 1'b0;
`endif

    // Grant for the command placed on the bus next cycle.
    always_comb begin
        w_next = S_IDLE;
        if (i_disp_req)
            w_next = S_RD;
        else if (w_clr_run)
            w_next = S_CLR;
        else if (i_wr_req && !r_wr_ack && !w_wr_block)
            w_next = S_WR;
    end

    always_ff @(posedge i_sysclk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_wr_ack     <= 1'b0;
            r_rd_pend    <= 1'b0;
            r_disp_valid <= 1'b0;
            r_disp_data  <= '0;
        end else begin
            r_state  <= w_next;
            r_mem_en <= (w_next != S_IDLE);
            r_mem_we <= (w_next == S_WR) || (w_next == S_CLR);
            r_wr_ack <= (w_next == S_WR);
            case (w_next)
                S_RD: r_mem_addr <= i_disp_addr;
                S_WR: begin
                    r_mem_addr  <= i_wr_addr;
                    r_mem_wdata <= i_wr_data;
                end
`ifdef FB_CLEAR_EN
                S_CLR: begin
                    r_mem_addr  <= r_clr_addr;
                    r_mem_wdata <= CLEAR_VALUE;
                end
`endif
                default: ;
            endcase
            // r_state==S_RD marks a read on the bus; its data arrives one cycle later.
            r_rd_pend    <= (r_state == S_RD);
            r_disp_valid <= r_rd_pend;
            if (r_rd_pend)
                r_disp_data <= i_mem_rdata;
        end
    end

    always_ff @(posedge i_sysclk) begin
        if (i_rst) begin
            r_wait_cnt <= '0;
            r_starve   <= 1'b0;
        end else begin
            if (i_wr_req && !r_wr_ack) begin
                if (r_wait_cnt != CNT_W'(WR_TIMEOUT + 1))
                    r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end else begin
                r_wait_cnt <= '0;
            end
            if (r_wait_cnt > CNT_W'(WR_TIMEOUT))
                r_starve <= 1'b1;
        end
    end

    assign o_mem_en     = r_mem_en;
    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_wr_ack     = r_wr_ack;
    assign o_wr_starve  = r_starve;
    assign o_disp_valid = r_disp_valid;
    assign o_disp_data  = r_disp_data;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: cycle table plus reset, burst, starve
// and (with FB_CLEAR_EN) clear-engine sequences against a behavioural RAM.
module tb_vga_fb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        disp_req;
    logic [19:0] disp_addr;
    logic [2:0]  disp_data;
    logic        disp_valid;
    logic        wr_req;
    logic [19:0] wr_addr;
    logic [2:0]  wr_data;
    logic        wr_ack;
    logic        wr_starve;
    logic        mem_en;
    logic        mem_we;
    logic [19:0] mem_addr;
    logic [2:0]  mem_wdata;
    logic [2:0]  mem_rdata;
    logic        mem_init;
    logic [2:0]  mem [0:1023];
`ifdef FB_CLEAR_EN
    logic        clear_start;
    logic        clear_busy;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_fb_arbiter #(
        .ADDR_W(20), .DATA_W(3), .WR_TIMEOUT(64)
`ifdef FB_CLEAR_EN
        , .FB_DEPTH(16), .CLEAR_VALUE(3'b000)
`endif
    ) dut (
        .i_sysclk(clk), .i_rst(rst),
        .i_disp_req(disp_req), .i_disp_addr(disp_addr),
        .o_disp_data(disp_data), .o_disp_valid(disp_valid),
        .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .o_wr_ack(wr_ack), .o_wr_starve(wr_starve),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
`ifdef FB_CLEAR_EN
        , .i_clear_start(clear_start), .o_clear_busy(clear_busy)
`endif
    );

    function automatic logic [2:0] fpix(input int a);
        return 3'(a + 5);
    endfunction

    // Single-port RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= fpix(i);
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[9:0]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        dreq;
        logic [19:0] daddr;
        logic        wreq;
        logic [19:0] waddr;
        logic [2:0]  wdat;
        logic        en;
        logic        we;
        logic [19:0] addr;
        logic [2:0]  wdata;
        logic        ack;
        logic        dv;
        logic [2:0]  ddata;
    } vec_t;

    vec_t vt [13];

    initial begin
        int idx, cnt, nclr, zeros;
        logic bad, seen;

        // row: inputs driven this cycle | outputs expected this cycle
        vt[0]  = '{1'b1, 20'h10,  1'b0, 20'h0,   3'd0, 1'b0, 1'b0, 20'h0,   3'd0, 1'b0, 1'b0, 3'd0};
        vt[1]  = '{1'b0, 20'h0,   1'b0, 20'h0,   3'd0, 1'b1, 1'b0, 20'h10,  3'd0, 1'b0, 1'b0, 3'd0};
        vt[2]  = '{1'b0, 20'h0,   1'b0, 20'h0,   3'd0, 1'b0, 1'b0, 20'h10,  3'd0, 1'b0, 1'b0, 3'd0};
        vt[3]  = '{1'b0, 20'h0,   1'b0, 20'h0,   3'd0, 1'b0, 1'b0, 20'h10,  3'd0, 1'b0, 1'b1, 3'd5};
        vt[4]  = '{1'b0, 20'h0,   1'b1, 20'h123, 3'd6, 1'b0, 1'b0, 20'h10,  3'd0, 1'b0, 1'b0, 3'd0};
        vt[5]  = '{1'b0, 20'h0,   1'b1, 20'h123, 3'd6, 1'b1, 1'b1, 20'h123, 3'd6, 1'b1, 1'b0, 3'd0};
        vt[6]  = '{1'b0, 20'h0,   1'b1, 20'h123, 3'd6, 1'b0, 1'b0, 20'h123, 3'd6, 1'b0, 1'b0, 3'd0};
        vt[7]  = '{1'b0, 20'h0,   1'b0, 20'h0,   3'd0, 1'b1, 1'b1, 20'h123, 3'd6, 1'b1, 1'b0, 3'd0};
        vt[8]  = '{1'b1, 20'h21,  1'b1, 20'h124, 3'd3, 1'b0, 1'b0, 20'h123, 3'd6, 1'b0, 1'b0, 3'd0};
        vt[9]  = '{1'b0, 20'h0,   1'b1, 20'h124, 3'd3, 1'b1, 1'b0, 20'h21,  3'd6, 1'b0, 1'b0, 3'd0};
        vt[10] = '{1'b0, 20'h0,   1'b1, 20'h124, 3'd3, 1'b1, 1'b1, 20'h124, 3'd3, 1'b1, 1'b0, 3'd0};
        vt[11] = '{1'b0, 20'h0,   1'b0, 20'h0,   3'd0, 1'b0, 1'b0, 20'h124, 3'd3, 1'b0, 1'b1, 3'd6};
        vt[12] = '{1'b0, 20'h0,   1'b0, 20'h0,   3'd0, 1'b0, 1'b0, 20'h124, 3'd3, 1'b0, 1'b0, 3'd0};

        // Reset with requests asserted: everything must stay at zero.
        rst = 1'b1; mem_init = 1'b1;
        disp_req = 1'b1; disp_addr = 20'h10;
        wr_req = 1'b1; wr_addr = 20'h55; wr_data = 3'd7;
`ifdef FB_CLEAR_EN
        clear_start = 1'b0;
`endif
        repeat (3) begin
            @(negedge clk);
            chk("rst_outs", {disp_valid, disp_data, wr_ack, wr_starve, mem_en, mem_we, mem_wdata}, 32'h0);
            chk("rst_addr", mem_addr, 32'h0);
        end
        rst = 1'b0; mem_init = 1'b0;
        disp_req = 1'b0; disp_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            chk($sformatf("row%0d_en", i), mem_en, vt[i].en);
            chk($sformatf("row%0d_we", i), mem_we, vt[i].we);
            chk($sformatf("row%0d_addr", i), mem_addr, vt[i].addr);
            chk($sformatf("row%0d_ack", i), wr_ack, vt[i].ack);
            chk($sformatf("row%0d_dv", i), disp_valid, vt[i].dv);
            chk($sformatf("row%0d_starve", i), wr_starve, 1'b0);
            if (vt[i].we) chk($sformatf("row%0d_wdata", i), mem_wdata, vt[i].wdata);
            if (vt[i].dv) chk($sformatf("row%0d_ddata", i), disp_data, vt[i].ddata);
            disp_req = vt[i].dreq; disp_addr = vt[i].daddr;
            wr_req = vt[i].wreq; wr_addr = vt[i].waddr; wr_data = vt[i].wdat;
        end
        chk("ram_0x123", mem[12'h123], 3'd6);
        chk("ram_0x124", mem[12'h124], 3'd3);

        // Reset while a read is in flight: its disp_valid must never appear.
        @(negedge clk); disp_req = 1'b1; disp_addr = 20'h10;
        @(negedge clk); disp_req = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("midrst_en", mem_en, 1'b0);
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (disp_valid) cnt++;
        end
        chk("midrst_no_dv", cnt, 0);

        // 16 back-to-back reads: in order, data in cycle k+3, no gaps.
        idx = 0; bad = 1'b0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (disp_valid) begin
                if (idx >= 16 || c != idx + 3 || disp_data !== fpix(32 + idx)) bad = 1'b1;
                idx++;
            end
            disp_req = (c < 16);
            disp_addr = 20'(32 + c);
        end
        chk("burst_count", idx, 16);
        chk("burst_order", bad, 1'b0);

        // Continuous display starves a held write.
        @(negedge clk);
        disp_req = 1'b1; disp_addr = 20'h30; wr_req = 1'b1; wr_addr = 20'h40; wr_data = 3'd1;
        cnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (wr_ack) cnt++;
        end
        chk("starve_early", wr_starve, 1'b0);
        repeat (10) begin
            @(negedge clk);
            if (wr_ack) cnt++;
        end
        chk("starve_set", wr_starve, 1'b1);
        chk("starve_no_ack", cnt, 0);
        disp_req = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            @(negedge clk);
            if (wr_ack) seen = 1'b1;
        end
        chk("starve_ack_after", seen, 1'b1);
        wr_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("starve_sticky", wr_starve, 1'b1);

`ifdef FB_CLEAR_EN
        // Clear with a writer waiting: 16 zero writes in order, writer held off.
        @(negedge clk);
        clear_start = 1'b1; wr_req = 1'b1; wr_addr = 20'h200; wr_data = 3'd7;
        @(negedge clk);
        clear_start = 1'b0;
        chk("clr_busy_rise", clear_busy, 1'b1);
        nclr = 0; bad = 1'b0; seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            if (!clear_busy) seen = 1'b1;
            else begin
                if (wr_ack) bad = 1'b1;
                if (mem_en && mem_we) begin
                    if (mem_addr !== 20'(nclr) || mem_wdata !== 3'd0) bad = 1'b1;
                    nclr++;
                end
                @(negedge clk);
            end
        end
        chk("clr_done", seen, 1'b1);
        chk("clr_writes", nclr, 16);
        chk("clr_seq", bad, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            if (wr_ack) seen = 1'b1;
            else @(negedge clk);
        end
        chk("clr_writer_ack", seen, 1'b1);
        chk("clr_writer_addr", mem_addr, 20'h200);
        wr_req = 1'b0;
        zeros = 0;
        for (int i = 0; i < 16; i++) if (mem[i] == 3'd0) zeros++;
        chk("clr_ram_zero", zeros, 16);

        // Reset in the middle of a clear aborts it.
        @(negedge clk); clear_start = 1'b1;
        @(negedge clk); clear_start = 1'b0;
        repeat (4) @(negedge clk);
        chk("clr2_busy", clear_busy, 1'b1);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("clr_rst_busy", clear_busy, 1'b0);
        chk("clr_rst_en", mem_en, 1'b0);
        @(negedge clk);
        chk("clr_rst_stays", clear_busy, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
